// File: rtl/issue_queue_free_list_if.sv
// Allocation/release bus between the scheduler (master) and the issue-queue free list (slave).
interface issue_queue_free_list_if #(
    parameter int unsigned ENTRY_NUM      = 16,
    parameter int unsigned DISPATCH_WIDTH = 2,
    parameter int unsigned RELEASE_WIDTH  = 2,
    parameter int unsigned IDX_W          = $clog2(ENTRY_NUM)
);
    logic                                     flush;
    logic [DISPATCH_WIDTH-1:0]                allocReq;
    logic [DISPATCH_WIDTH-1:0][IDX_W-1:0]     allocPtr;
    logic                                     allocatable;
    logic [RELEASE_WIDTH-1:0]                 releaseEntry;
    logic [RELEASE_WIDTH-1:0][IDX_W-1:0]      releasePtr;
    logic [IDX_W:0]                           freeCount;
    logic                                     error;

    modport master (
        output flush, allocReq, releaseEntry, releasePtr,
        input  allocPtr, allocatable, freeCount, error
    );

    modport slave (
        input  flush, allocReq, releaseEntry, releasePtr,
        output allocPtr, allocatable, freeCount, error
    );
endinterface

// File: rtl/issue_queue_free_list.sv
// Circular free list of issue-queue entry indices: combinational allocation read,
// multi-lane release write, sticky underflow/overflow detection.
module issue_queue_free_list #(
    parameter int unsigned ENTRY_NUM      = 16,
    parameter int unsigned DISPATCH_WIDTH = 2,
    parameter int unsigned RELEASE_WIDTH  = 2,
    parameter int unsigned IDX_W          = $clog2(ENTRY_NUM)
) (
    input logic                  clk,
    input logic                  rst,
    issue_queue_free_list_if.slave bus
);
    localparam int unsigned CntW = IDX_W + 2;

    logic [IDX_W-1:0] list_q [ENTRY_NUM];
    logic [IDX_W-1:0] head_q, tail_q;
    logic [IDX_W:0]   count_q;
    logic             error_q;

    logic [CntW-1:0]  pre_a [DISPATCH_WIDTH];
    logic [CntW-1:0]  pre_r [RELEASE_WIDTH];
    logic [CntW-1:0]  n_alloc, n_rel, next_cnt;
    logic [IDX_W-1:0] rd_addr [DISPATCH_WIDTH];
    logic [IDX_W-1:0] wr_addr [RELEASE_WIDTH];
    logic             underflow, overflow;

    // Per-lane offsets are prefix popcounts so sparse lanes pack densely.
    always_comb begin
        pre_a[0] = '0;
        for (int i = 1; i < DISPATCH_WIDTH; i++) begin
            pre_a[i] = pre_a[i-1] + CntW'(bus.allocReq[i-1]);
        end
        n_alloc = pre_a[DISPATCH_WIDTH-1] + CntW'(bus.allocReq[DISPATCH_WIDTH-1]);
        pre_r[0] = '0;
        for (int j = 1; j < RELEASE_WIDTH; j++) begin
            pre_r[j] = pre_r[j-1] + CntW'(bus.releaseEntry[j-1]);
        end
        n_rel = pre_r[RELEASE_WIDTH-1] + CntW'(bus.releaseEntry[RELEASE_WIDTH-1]);
    end

    always_comb begin
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            rd_addr[i]      = head_q + pre_a[i][IDX_W-1:0];
            bus.allocPtr[i] = list_q[rd_addr[i]];
        end
        for (int j = 0; j < RELEASE_WIDTH; j++) begin
            wr_addr[j] = tail_q + pre_r[j][IDX_W-1:0];
        end
    end

    always_comb begin
        next_cnt  = CntW'(count_q) - n_alloc + n_rel;
        underflow = n_alloc > CntW'(count_q);
        overflow  = !underflow && (next_cnt > CntW'(ENTRY_NUM));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < ENTRY_NUM; k++) begin
                list_q[k] <= IDX_W'(k);
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= (IDX_W+1)'(ENTRY_NUM);
            error_q <= 1'b0;
        end else if (bus.flush) begin
            for (int k = 0; k < ENTRY_NUM; k++) begin
                list_q[k] <= IDX_W'(k);
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= (IDX_W+1)'(ENTRY_NUM);
        end else if (underflow || overflow) begin
            error_q <= 1'b1;
        end else begin
            for (int j = 0; j < RELEASE_WIDTH; j++) begin
                if (bus.releaseEntry[j]) begin
                    list_q[wr_addr[j]] <= bus.releasePtr[j];
                end
            end
            head_q  <= head_q + n_alloc[IDX_W-1:0];
            tail_q  <= tail_q + n_rel[IDX_W-1:0];
            count_q <= next_cnt[IDX_W:0];
        end
    end

    assign bus.freeCount   = count_q;
    assign bus.allocatable = count_q >= (IDX_W+1)'(DISPATCH_WIDTH);
    assign bus.error       = error_q;
endmodule

// File: tb/tb_issue_queue_free_list.sv
// Directed vector bench for issue_queue_free_list; expected values are pre-edge observations.
module tb_issue_queue_free_list;
    localparam int N = 16;
    localparam int W = 4;

    typedef struct {
        bit       do_rst;
        bit       fl;
        bit [1:0] areq;
        bit [1:0] rel;
        bit [3:0] rp0, rp1;
        bit [1:0] chk;
        bit [3:0] e0, e1;
        int       ecnt;
        bit       ealloc;
        bit       eerr;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;
    vec_t vt [26];

    issue_queue_free_list_if #(.ENTRY_NUM(N), .DISPATCH_WIDTH(2), .RELEASE_WIDTH(2)) bus ();

    issue_queue_free_list #(.ENTRY_NUM(N), .DISPATCH_WIDTH(2), .RELEASE_WIDTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input int idx, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s vec=%0d actual=%0d required=%0d", name, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(bit r, bit f, bit [1:0] a, bit [1:0] rl, bit [3:0] p0,
                                bit [3:0] p1, bit [1:0] c, bit [3:0] x0, bit [3:0] x1,
                                int cnt, bit al, bit er);
        vec_t v;
        v.do_rst = r; v.fl = f; v.areq = a; v.rel = rl; v.rp0 = p0; v.rp1 = p1;
        v.chk = c; v.e0 = x0; v.e1 = x1; v.ecnt = cnt; v.ealloc = al; v.eerr = er;
        return v;
    endfunction

    initial begin
        bus.flush = 0; bus.allocReq = 0; bus.releaseEntry = 0; bus.releasePtr = '0;
        // Drain all 16 in pairs.
        for (int k = 0; k < 8; k++) begin
            vt[k] = mk(k == 0, 0, 2'b11, 0, 0, 0, 2'b11, 4'(2*k), 4'(2*k+1), N-2*k, 1, 0);
        end
        vt[8]  = mk(0, 0, 2'b00, 2'b11, 9, 4, 0, 0, 0, 0, 0, 0);
        vt[9]  = mk(0, 0, 2'b11, 2'b01, 7, 0, 2'b11, 9, 4, 2, 1, 0);
        vt[10] = mk(0, 0, 2'b01, 0, 0, 0, 2'b01, 7, 0, 1, 0, 0);
        vt[11] = mk(0, 0, 2'b00, 2'b10, 0, 5, 0, 0, 0, 0, 0, 0);
        vt[12] = mk(0, 0, 2'b11, 0, 0, 0, 2'b01, 5, 0, 1, 0, 0);      // underflow
        vt[13] = mk(0, 0, 2'b01, 0, 0, 0, 2'b01, 5, 0, 1, 0, 1);
        vt[14] = mk(0, 0, 2'b00, 2'b11, 3, 8, 0, 0, 0, 0, 0, 1);
        vt[15] = mk(0, 0, 2'b00, 2'b11, 10, 11, 0, 0, 0, 2, 1, 1);
        vt[16] = mk(0, 0, 2'b00, 2'b01, 12, 0, 0, 0, 0, 4, 1, 1);
        vt[17] = mk(0, 1, 2'b11, 2'b01, 13, 0, 2'b11, 3, 8, 5, 1, 1);  // flush
        vt[18] = mk(0, 0, 2'b11, 0, 0, 0, 2'b11, 0, 1, 16, 1, 1);
        vt[19] = mk(1, 0, 2'b10, 0, 0, 0, 2'b10, 0, 0, 16, 1, 0);      // sparse lane
        vt[20] = mk(0, 0, 2'b01, 0, 0, 0, 2'b01, 1, 0, 15, 1, 0);
        vt[21] = mk(0, 0, 2'b00, 2'b01, 0, 0, 0, 0, 0, 14, 1, 0);
        vt[22] = mk(0, 0, 2'b00, 2'b01, 1, 0, 0, 0, 0, 15, 1, 0);
        vt[23] = mk(0, 0, 2'b00, 2'b01, 5, 0, 0, 0, 0, 16, 1, 0);      // overflow
        vt[24] = mk(0, 0, 2'b11, 0, 0, 0, 2'b11, 2, 3, 16, 1, 1);
        vt[25] = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 14, 1, 1);

        #3 rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 26; i++) begin
            if (vt[i].do_rst) begin
                // Asynchronous reset pulse between edges; state must settle without a clock.
                #1 rst = 1'b0;
                #1;
                cmp("rst_freeCount", i, int'(bus.freeCount), N);
                cmp("rst_error", i, int'(bus.error), 0);
                cmp("rst_allocatable", i, int'(bus.allocatable), 1);
                #1 rst = 1'b1;
            end else begin
                #1;
            end
            bus.flush        = vt[i].fl;
            bus.allocReq     = vt[i].areq;
            bus.releaseEntry = vt[i].rel;
            bus.releasePtr   = {vt[i].rp1, vt[i].rp0};
            #1;
            if (vt[i].chk[0]) cmp("allocPtr0", i, int'(bus.allocPtr[0]), int'(vt[i].e0));
            if (vt[i].chk[1]) cmp("allocPtr1", i, int'(bus.allocPtr[1]), int'(vt[i].e1));
            cmp("freeCount", i, int'(bus.freeCount), vt[i].ecnt);
            cmp("allocatable", i, int'(bus.allocatable), int'(vt[i].ealloc));
            cmp("error", i, int'(bus.error), int'(vt[i].eerr));
            @(negedge clk);
            bus.flush = 0; bus.allocReq = 0; bus.releaseEntry = 0;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
